// File: rtl/conv33_pkg.sv
// Shared constants for the conv33 window generator and the conv33 convolution stage.
package conv33_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;
    localparam int MAX_DIM        = 1024;
    // Counter width sized for the largest legal image dimension, so the
    // row/col counters are the same width in conv33 and conv33_window.
    localparam int CNT_W          = $clog2(MAX_DIM);
endpackage

// File: rtl/conv33_window_if.sv
// Pixel-stream in, 3x3 window out; the window block is the slave side.
interface conv33_window_if #(parameter int DATA_WIDTH = 8);
    logic                  pix_valid;
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  win_valid;
    logic                  frame_done;
    logic [DATA_WIDTH-1:0] out_0_0, out_0_1, out_0_2;
    logic [DATA_WIDTH-1:0] out_1_0, out_1_1, out_1_2;
    logic [DATA_WIDTH-1:0] out_2_0, out_2_1, out_2_2;

    modport master (
        output pix_valid, pix_data,
        input  win_valid, frame_done,
        input  out_0_0, out_0_1, out_0_2, out_1_0, out_1_1, out_1_2,
               out_2_0, out_2_1, out_2_2
    );
    modport slave (
        input  pix_valid, pix_data,
        output win_valid, frame_done,
        output out_0_0, out_0_1, out_0_2, out_1_0, out_1_1, out_1_2,
               out_2_0, out_2_1, out_2_2
    );
endinterface

// File: rtl/conv33_line_buf.sv
// One image row of storage: single address, combinational read, write on clock.
module conv33_line_buf
    import conv33_pkg::*;
#(
    parameter int DEPTH      = DEF_IMG_W,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // rdata shows the old contents during a write, giving read-before-write.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/conv33_window.sv
// Raster-order pixel stream to 3x3 neighbourhood windows for conv33 (valid conv, no padding).
module conv33_window
    import conv33_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H
) (
    input  logic          clk,
    input  logic          rst,
    conv33_window_if.slave bus
);
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

    logic [CNT_W-1:0]                col, row;
    logic [DATA_WIDTH-1:0]           lb1_q, lb0_q;
    logic [2:0][2:0][DATA_WIDTH-1:0] win;
    logic                            win_valid, frame_done;
    logic                            last_col, last_row;

    assign last_col = (col == LAST_COL);
    assign last_row = (row == LAST_ROW);

    // lb1 holds the previous row; its old value cascades into lb0 (two rows back).
    conv33_line_buf #(.DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_lb1 (
        .clk   (clk),
        .we    (bus.pix_valid),
        .addr  (col[AW-1:0]),
        .wdata (bus.pix_data),
        .rdata (lb1_q)
    );

    conv33_line_buf #(.DEPTH(IMG_W), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_lb0 (
        .clk   (clk),
        .we    (bus.pix_valid),
        .addr  (col[AW-1:0]),
        .wdata (lb1_q),
        .rdata (lb0_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            win        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (bus.pix_valid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= lb0_q;
                win[1][2] <= lb1_q;
                win[2][2] <= bus.pix_data;
                // Stale rows/columns only occupy the window while col<2 or row<2.
                win_valid  <= (col >= CNT_W'(2)) && (row >= CNT_W'(2));
                frame_done <= last_col && last_row;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign bus.win_valid  = win_valid;
    assign bus.frame_done = frame_done;
    assign bus.out_0_0 = win[0][0];
    assign bus.out_0_1 = win[0][1];
    assign bus.out_0_2 = win[0][2];
    assign bus.out_1_0 = win[1][0];
    assign bus.out_1_1 = win[1][1];
    assign bus.out_1_2 = win[1][2];
    assign bus.out_2_0 = win[2][0];
    assign bus.out_2_1 = win[2][1];
    assign bus.out_2_2 = win[2][2];
endmodule

// File: tb/tb_conv33_window.sv
// Bench for conv33_window: 5x5 DUT against an image-array model, 3x3 DUT from a vector table.
module tb_conv33_window;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv33_window_if #(.DATA_WIDTH(8)) b5 ();
    conv33_window_if #(.DATA_WIDTH(8)) b3 ();

    conv33_window #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(5)) u5 (.clk(clk), .rst(rst), .bus(b5));
    conv33_window #(.DATA_WIDTH(8), .IMG_W(3), .IMG_H(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    logic [71:0] w5, w3;
    assign w5 = {b5.out_0_0, b5.out_0_1, b5.out_0_2, b5.out_1_0, b5.out_1_1,
                 b5.out_1_2, b5.out_2_0, b5.out_2_1, b5.out_2_2};
    assign w3 = {b3.out_0_0, b3.out_0_1, b3.out_0_2, b3.out_1_0, b3.out_1_1,
                 b3.out_1_2, b3.out_2_0, b3.out_2_1, b3.out_2_2};

    int checks = 0;
    int failures = 0;

    // Reference model: the current frame as a 2-D image, filled by pixel index.
    int          n5 = 0;
    logic [7:0]  img5 [5][5];
    logic [71:0] wins5 [$];

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        ev;
        logic        ef;
        logic [71:0] ew;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step5(input logic v, input logic [7:0] d);
        logic ev, ef;
        logic [71:0] ew;
        int r, c;
        ev = 1'b0; ef = 1'b0; ew = '0;
        b5.pix_valid = v;
        b5.pix_data  = d;
        if (v) begin
            r = n5 / 5;
            c = n5 % 5;
            img5[r][c] = d;
            if (r >= 2 && c >= 2) begin
                ev = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew = {ew[63:0], img5[r-2+i][c-2+j]};
            end
            ef = (n5 == 24);
            n5 = (n5 + 1) % 25;
        end
        @(posedge clk);
        @(negedge clk);
        chk("win_valid5", {71'b0, b5.win_valid}, {71'b0, ev});
        chk("frame_done5", {71'b0, b5.frame_done}, {71'b0, ef});
        if (b5.win_valid) begin
            wins5.push_back(w5);
            if (ev) chk("window5", w5, ew);
        end
    endtask

    task automatic send_frame5(input int base, input bit gaps);
        for (int n = 0; n < 25; n++) begin
            if (gaps) repeat ($urandom_range(1, 5)) step5(1'b0, 8'h00);
            step5(1'b1, 8'(base + (n / 5) * 5 + (n % 5)));
        end
        step5(1'b0, 8'h00);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_win5"}, w5, '0);
        chk({tag, "_ctl5"}, {70'b0, b5.win_valid, b5.frame_done}, '0);
    endtask

    localparam logic [71:0] FIRST_W  = 72'h00_01_02_05_06_07_0a_0b_0c;
    localparam logic [71:0] LAST_W   = 72'h0c_0d_0e_11_12_13_16_17_18;
    localparam logic [71:0] FIRST_W2 = 72'h64_65_66_69_6a_6b_6e_6f_70;

    initial begin
        b5.pix_valid = 1'b0; b5.pix_data = '0;
        b3.pix_valid = 1'b0; b3.pix_data = '0;

        // 3x3 frame, pixels 1..9: one window on the last pixel, with frame_done.
        for (int i = 0; i < 9; i++) begin
            tbl[i].v  = 1'b1;
            tbl[i].d  = 8'(i + 1);
            tbl[i].ev = (i == 8);
            tbl[i].ef = (i == 8);
            tbl[i].ew = (i == 8) ? 72'h01_02_03_04_05_06_07_08_09 : 72'h0;
        end
        tbl[9].v = 1'b0; tbl[9].d = 8'h00; tbl[9].ev = 1'b0; tbl[9].ef = 1'b0; tbl[9].ew = '0;

        repeat (2) @(negedge clk);
        check_zero("reset");
        chk("reset_win3", w3, '0);
        chk("reset_ctl3", {70'b0, b3.win_valid, b3.frame_done}, '0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            b3.pix_valid = tbl[i].v;
            b3.pix_data  = tbl[i].d;
            @(posedge clk);
            @(negedge clk);
            chk("tbl_valid3", {71'b0, b3.win_valid}, {71'b0, tbl[i].ev});
            chk("tbl_done3", {71'b0, b3.frame_done}, {71'b0, tbl[i].ef});
            if (tbl[i].ev) chk("tbl_window3", w3, tbl[i].ew);
        end

        // Continuous frame.
        wins5.delete();
        send_frame5(0, 1'b0);
        chk("cont_count", 72'(wins5.size()), 72'd9);
        if (wins5.size() == 9) begin
            chk("cont_first", wins5[0], FIRST_W);
            chk("cont_last", wins5[8], LAST_W);
        end

        // Same frame with idle gaps.
        wins5.delete();
        send_frame5(0, 1'b1);
        chk("gap_count", 72'(wins5.size()), 72'd9);
        if (wins5.size() == 9) begin
            chk("gap_first", wins5[0], FIRST_W);
            chk("gap_last", wins5[8], LAST_W);
        end

        // Two frames back to back, second offset by 100.
        wins5.delete();
        for (int n = 0; n < 50; n++)
            step5(1'b1, 8'((n >= 25 ? 100 : 0) + ((n % 25) / 5) * 5 + (n % 5)));
        step5(1'b0, 8'h00);
        chk("b2b_count", 72'(wins5.size()), 72'd18);
        if (wins5.size() == 18) chk("b2b_first2", wins5[9], FIRST_W2);

        // Asynchronous reset right after pixel 17, mid-frame.
        for (int n = 0; n < 18; n++) step5(1'b1, 8'((n / 5) * 5 + (n % 5)));
        b5.pix_valid = 1'b0;
        chk("pre_rst_valid", {71'b0, b5.win_valid}, 72'd1);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk);
        check_zero("held_rst");
        rst = 1'b1;
        n5 = 0;
        wins5.delete();
        send_frame5(0, 1'b0);
        chk("rst_count", 72'(wins5.size()), 72'd9);
        if (wins5.size() == 9) begin
            chk("rst_first", wins5[0], FIRST_W);
            chk("rst_last", wins5[8], LAST_W);
        end

        // Alternating 255/0 for bit-exact transport.
        wins5.delete();
        for (int n = 0; n < 25; n++) step5(1'b1, (n % 2 == 0) ? 8'hff : 8'h00);
        step5(1'b0, 8'h00);
        chk("alt_count", 72'(wins5.size()), 72'd9);

        // Random data with random gaps over two frames.
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 3) == 0) step5(1'b0, 8'($urandom));
            step5(1'b1, 8'($urandom));
        end
        step5(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
